// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO controller slice: default sizing,
// pointer/count width and the RAM read latency that sets the valid pipeline depth.
package fifo_pkg;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

   // Pointers and occupancy carry one extra bit beyond the RAM address.
   function automatic int ptr_w(input int addr);
      return addr + 1;
   endfunction

   localparam int DEPTH_DEF  = 8192;
   localparam int ADDR_DEF   = clog2(DEPTH_DEF);
   localparam int PTR_W_DEF  = ptr_w(ADDR_DEF);
   localparam int RAM_RD_LAT = 2;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: W-bit register (MSB is the wrap bit) with increment
// enable and synchronous active-high reset; only the RAM address bits leave.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int W = PTR_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-2:0] addr
);

   logic [W-1:0] ptr_q;

   always_ff @(posedge clk) begin
      if (reset)
         ptr_q <= '0;
      else if (inc)
         ptr_q <= ptr_q + W'(1);
   end

   assign addr = ptr_q[W-2:0];

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller driving a simple-dual-port RAM with 2-cycle read
// latency. Optional almost_full/almost_empty comparators: `FIFO_ALMOST_FLAGS_EN.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR      = ADDR_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic            rd_en,
   output logic            ram_wr_en,
   output logic [ADDR-1:0] ram_wr_addr,
   output logic            ram_rd_en,
   output logic [ADDR-1:0] ram_rd_addr,
   output logic            rd_valid,
   output logic            full,
   output logic            empty,
   output logic            almost_full,
   output logic            almost_empty,
   output logic [ADDR:0]   count,
   output logic            overflow,
   output logic            underflow
);

   localparam int CNT_W = ptr_w(ADDR);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic                  wr_acc;
   logic                  rd_acc;
   logic [CNT_W-1:0]      count_nxt;
   logic [RAM_RD_LAT-1:0] vld_p;

   // Acceptance looks only at registered flags, so wr_en and rd_en never cross.
   assign wr_acc    = wr_en & ~full  & ~reset;
   assign rd_acc    = rd_en & ~empty & ~reset;
   assign ram_wr_en = wr_acc;
   assign ram_rd_en = rd_acc;

   fifo_ptr #(.W(CNT_W)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_acc),
      .addr  (ram_wr_addr)
   );

   fifo_ptr #(.W(CNT_W)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (rd_acc),
      .addr  (ram_rd_addr)
   );

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)
         count_nxt = count + CNT_W'(1);
      else if (rd_acc && !wr_acc)
         count_nxt = count - CNT_W'(1);
   end

   // Stage boundary: occupancy, flags, reject pulses and the read-valid shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         vld_p     <= '0;
      end else begin
         count     <= count_nxt;
         full      <= (count_nxt == DEPTH_C);
         empty     <= (count_nxt == '0);
         overflow  <= wr_en & full;
         underflow <= rd_en & empty;
         vld_p     <= {vld_p[RAM_RD_LAT-2:0], rd_acc};
      end
   end

   assign rd_valid = vld_p[RAM_RD_LAT-1];

`ifdef FIFO_ALMOST_FLAGS_EN
   localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_THRESH);

   always_ff @(posedge clk) begin
      if (reset) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
      end
   end
`else
   assign almost_full  = 1'b0;
   assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (DEPTH=8) with a behavioural 2-cycle-latency RAM
// and a data scoreboard; almost-flag expectations follow FIFO_ALMOST_FLAGS_EN.
module tb_fifo_ctrl;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] wr_data;
   logic       ram_wr_en;
   logic [2:0] ram_wr_addr;
   logic       ram_rd_en;
   logic [2:0] ram_rd_addr;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   fifo_ctrl #(
      .ADDR      (3),
      .DEPTH     (8),
      .AF_THRESH (6),
      .AE_THRESH (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .ram_wr_en    (ram_wr_en),
      .ram_wr_addr  (ram_wr_addr),
      .ram_rd_en    (ram_rd_en),
      .ram_rd_addr  (ram_rd_addr),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: registered read through two stages.
   logic [7:0] mem [8];
   logic [7:0] rd_s1;
   logic [7:0] rd_dataout;
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= wr_data;
      if (ram_rd_en) rd_s1 <= mem[ram_rd_addr];
      rd_dataout <= rd_s1;
   end

   int n_asserts = 0;
   int n_fail    = 0;
   logic [7:0] sb [$];

   int   m_count, m_wp, m_rp;
   logic m_full, m_empty, m_af, m_ae, m_ovf, m_unf, mv1, mv2;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_valid) begin
         chk("rd_sb_nonempty", 16'(sb.size() != 0), 16'd1);
         if (sb.size() != 0) chk("rd_data", 16'(rd_dataout), 16'(sb.pop_front()));
      end
   end

   task automatic upd_flags();
      m_full  = (m_count == 8);
      m_empty = (m_count == 0);
`ifdef FIFO_ALMOST_FLAGS_EN
      m_af = (m_count >= 6);
      m_ae = (m_count <= 2);
`else
      m_af = 1'b0;
      m_ae = 1'b0;
`endif
   endtask

   task automatic check_state();
      chk("count",        16'(count),        16'(m_count));
      chk("full",         16'(full),         16'(m_full));
      chk("empty",        16'(empty),        16'(m_empty));
      chk("almost_full",  16'(almost_full),  16'(m_af));
      chk("almost_empty", 16'(almost_empty), 16'(m_ae));
      chk("overflow",     16'(overflow),     16'(m_ovf));
      chk("underflow",    16'(underflow),    16'(m_unf));
      chk("rd_valid",     16'(rd_valid),     16'(mv2));
   endtask

   // One clock cycle of stimulus; called just after a rising edge.
   task automatic cyc(input logic w, input logic r, input logic [7:0] d);
      logic ew, er;
      wr_en = w; rd_en = r; wr_data = d;
      #1;
      ew = w & ~m_full;
      er = r & ~m_empty;
      chk("ram_wr_en", 16'(ram_wr_en), 16'(ew));
      chk("ram_rd_en", 16'(ram_rd_en), 16'(er));
      if (ew) chk("ram_wr_addr", 16'(ram_wr_addr), 16'(m_wp % 8));
      if (er) chk("ram_rd_addr", 16'(ram_rd_addr), 16'(m_rp % 8));
      if (ew) sb.push_back(d);
      @(posedge clk); #1;
      m_ovf = w & m_full;
      m_unf = r & m_empty;
      if (ew) m_wp = (m_wp + 1) % 16;
      if (er) m_rp = (m_rp + 1) % 16;
      m_count = m_count + (ew ? 1 : 0) - (er ? 1 : 0);
      mv2 = mv1;
      mv1 = er;
      upd_flags();
      check_state();
   endtask

   // Reset cycle with both requests high to confirm the RAM enables stay low.
   task automatic rst_cyc();
      reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      #1;
      chk("rst_ram_wr_en", 16'(ram_wr_en), 16'd0);
      chk("rst_ram_rd_en", 16'(ram_rd_en), 16'd0);
      @(posedge clk); #1;
      m_count = 0; m_wp = 0; m_rp = 0;
      mv1 = 1'b0; mv2 = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      sb.delete();
      upd_flags();
      check_state();
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
      m_count = 0; m_wp = 0; m_rp = 0;
      mv1 = 1'b0; mv2 = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      upd_flags();

      // Reset then idle
      rst_cyc();
      cyc(1'b0, 1'b0, 8'h00);
      chk("idle_empty", 16'(empty), 16'd1);
      chk("idle_count", 16'(count), 16'd0);

      // Fill with 0x11..0x18, then one write too many
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h11 + i));
      chk("full_after8",  16'(full),  16'd1);
      chk("count_after8", 16'(count), 16'd8);
      cyc(1'b1, 1'b0, 8'h99);
      chk("ovf_pulse",  16'(overflow), 16'd1);
      chk("ovf_count",  16'(count),    16'd8);
      cyc(1'b0, 1'b0, 8'h00);
      chk("ovf_one_cycle", 16'(overflow), 16'd0);

      // Drain: the monitor checks 0x11..0x18 in order
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("drained_empty", 16'(empty), 16'd1);

      // Underflow, then simultaneous write+read while empty
      cyc(1'b0, 1'b1, 8'h00);
      chk("unf_pulse", 16'(underflow), 16'd1);
      cyc(1'b1, 1'b1, 8'h21);
      chk("empty_wr_rd_count", 16'(count), 16'd1);

      // Bring occupancy to 4, then sustained write+read across the pointer wrap
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h22 + i));
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 8'(8'h30 + i));
      chk("steady_count", 16'(count), 16'd4);

      // Reset with reads in flight
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b1, 8'h00);
      rst_cyc();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
      chk("post_rst_rd_valid", 16'(rd_valid), 16'd0);
      chk("post_rst_empty",    16'(empty),    16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
